pc_branch_unit: RTL and testbench

PC_BRANCH_UNIT -- requirements
Module: pc_branch_unit

---
 rtl/otter_pkg.sv | 27 ++
 rtl/branch_resolve.sv | 28 ++
 rtl/pc_branch_unit.sv | 129 ++++++++++++
 tb/tb_pc_branch_unit.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/otter_pkg.sv
// Shared encodings for the PC/branch unit: opcodes, branch func3 values and FSM states.
package otter_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    localparam logic [2:0] F3_MRET = 3'b000;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

    function automatic logic misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/branch_resolve.sv
// Pure combinational decision of a conditional branch from func3 and the rs1/rs2 compare flags.
module branch_resolve
    import otter_pkg::*;
(
    input  logic [2:0] func3,
    input  logic       br_eq,
    input  logic       br_lt,
    input  logic       br_ltu,
    output logic       take,
    output logic       illegal
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        take    = 1'b0;
        illegal = 1'b0;
        case (func3)
            F3_BEQ:  take = br_eq;
            F3_BNE:  take = !br_eq;
            F3_BLT:  take = br_lt;
            F3_BGE:  take = !br_lt;
            F3_BLTU: take = br_ltu;
            F3_BGEU: take = !br_ltu;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/pc_branch_unit.sv
// Program counter, fetch/exec sequencing and next-PC selection (branches, jumps, MRET, traps).
module pc_branch_unit
    import otter_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [6:0]       ir_opcode,
    input  logic [2:0]       ir_func3,
    input  logic             br_eq,
    input  logic             br_lt,
    input  logic             br_ltu,
    input  logic [31:0]      branch_tgt,
    input  logic [31:0]      jal_tgt,
    input  logic [31:0]      jalr_tgt,
    input  logic [31:0]      mtvec,
    input  logic [31:0]      mepc,
    input  logic             intr_pend,
    input  logic             exec_done,
    output logic             fetch_req,
    input  logic             fetch_ack,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             taken,
    output logic             trap,
    output logic             misalign,
    output logic             illegal_br,
    output logic [CNT_W-1:0] taken_cnt
);

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic        br_take, br_illegal;
    logic        is_exec, is_br, is_jal, is_jalr, is_mret, retire;
    logic        ctrl_xfer, mis_sel;
    logic [31:0] xfer_tgt, next_pc;

    // JALR clears bit 0 of its target, so that input bit never matters.
    logic jalr_lsb_unused;
    assign jalr_lsb_unused = jalr_tgt[0];

    branch_resolve u_branch_resolve (
        .func3   (ir_func3),
        .br_eq   (br_eq),
        .br_lt   (br_lt),
        .br_ltu  (br_ltu),
        .take    (br_take),
        .illegal (br_illegal)
    );

    assign is_exec = (state_q == ST_EXEC);
    assign is_br   = (ir_opcode == OP_BRANCH);
    assign is_jal  = (ir_opcode == OP_JAL);
    assign is_jalr = (ir_opcode == OP_JALR);
    assign is_mret = (ir_opcode == OP_SYSTEM) && (ir_func3 == F3_MRET);
    assign retire  = is_exec && exec_done;

    assign pc         = pc_q;
    assign pc_plus4   = pc_q + 32'd4;
    assign taken_cnt  = cnt_q;
    assign fetch_req  = (state_q == ST_FETCH);
    assign taken      = is_exec && ((is_br && br_take) || is_jal || is_jalr);
    assign illegal_br = is_exec && is_br && br_illegal;
    assign misalign   = retire && mis_sel;
    assign trap       = retire && (intr_pend || mis_sel);

    // Control-transfer target first, then the interrupt/MRET/misalign overrides on top of it.
    always_comb begin
        xfer_tgt  = pc_plus4;
        ctrl_xfer = 1'b0;
        if (is_jalr) begin
            xfer_tgt  = {jalr_tgt[31:1], 1'b0};
            ctrl_xfer = 1'b1;
        end else if (is_jal) begin
            xfer_tgt  = jal_tgt;
            ctrl_xfer = 1'b1;
        end else if (is_br && br_take) begin
            xfer_tgt  = branch_tgt;
            ctrl_xfer = 1'b1;
        end

        next_pc = xfer_tgt;
        mis_sel = 1'b0;
        if (intr_pend) begin
            next_pc = mtvec;
        end else if (is_mret) begin
            next_pc = mepc;
        end else if (ctrl_xfer && misaligned(xfer_tgt)) begin
            next_pc = mtvec;
            mis_sel = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_BOOT:  state_d = ST_FETCH;
            ST_FETCH: if (fetch_ack) state_d = ST_EXEC;
            ST_EXEC: begin
                if (exec_done) begin
                    state_d = ST_FETCH;
                    pc_d    = next_pc;
                    if (taken && !(&cnt_q)) cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default:  state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (RST) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed self-checking bench for pc_branch_unit with a 4-bit taken counter.
module tb_pc_branch_unit;
    import otter_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic [6:0]  ir_opcode;
    logic [2:0]  ir_func3;
    logic        br_eq, br_lt, br_ltu;
    logic [31:0] branch_tgt, jal_tgt, jalr_tgt, mtvec, mepc;
    logic        intr_pend, exec_done, fetch_ack;
    logic        fetch_req, taken, trap, misalign, illegal_br;
    logic [31:0] pc, pc_plus4;
    logic [3:0]  taken_cnt;

    int n_checks = 0;
    int n_err    = 0;
    logic [31:0] exp_pc  = 32'h0;
    int          exp_cnt = 0;

    always #5 CLK = ~CLK;

    pc_branch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(4)) dut (
        .CLK(CLK), .RST(RST), .ir_opcode(ir_opcode), .ir_func3(ir_func3),
        .br_eq(br_eq), .br_lt(br_lt), .br_ltu(br_ltu),
        .branch_tgt(branch_tgt), .jal_tgt(jal_tgt), .jalr_tgt(jalr_tgt),
        .mtvec(mtvec), .mepc(mepc), .intr_pend(intr_pend), .exec_done(exec_done),
        .fetch_req(fetch_req), .fetch_ack(fetch_ack), .pc(pc), .pc_plus4(pc_plus4),
        .taken(taken), .trap(trap), .misalign(misalign), .illegal_br(illegal_br),
        .taken_cnt(taken_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Enters at posedge+1 in FETCH; holds one cycle without ack (with ignored inputs), then acks.
    task automatic do_fetch(input string tag);
        check({tag, ".fetch_req"}, 32'(fetch_req), 32'd1);
        exec_done = 1'b1;
        intr_pend = 1'b1;
        @(posedge CLK); #1;
        check({tag, ".fetch_hold"}, 32'(fetch_req), 32'd1);
        check({tag, ".pc_stable"}, pc, exp_pc);
        exec_done = 1'b0;
        intr_pend = 1'b0;
        fetch_ack = 1'b1;
        @(posedge CLK); #1;
        fetch_ack = 1'b0;
        check({tag, ".in_exec"}, 32'(fetch_req), 32'd0);
    endtask

    // Enters at posedge+1 in EXEC; applies one instruction and retires it.
    task automatic exec_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                              input logic eq, input logic lt, input logic ltu, input logic intr,
                              input logic e_taken, input logic e_trap, input logic e_mis,
                              input logic e_ill, input logic [31:0] e_pc);
        ir_opcode = op;
        ir_func3  = f3;
        br_eq     = eq;
        br_lt     = lt;
        br_ltu    = ltu;
        intr_pend = intr;
        exec_done = 1'b1;
        #2;
        check({tag, ".taken"}, 32'(taken), 32'(e_taken));
        check({tag, ".trap"}, 32'(trap), 32'(e_trap));
        check({tag, ".misalign"}, 32'(misalign), 32'(e_mis));
        check({tag, ".illegal_br"}, 32'(illegal_br), 32'(e_ill));
        @(posedge CLK); #1;
        exec_done = 1'b0;
        intr_pend = 1'b0;
        if (e_taken && exp_cnt < 15) exp_cnt++;
        exp_pc = e_pc;
        check({tag, ".pc"}, pc, e_pc);
        check({tag, ".pc_plus4"}, pc_plus4, e_pc + 32'd4);
        check({tag, ".taken_cnt"}, 32'(taken_cnt), 32'(exp_cnt));
        check({tag, ".trap_end"}, 32'(trap | misalign), 32'd0);
    endtask

    initial begin
        RST = 1'b1; fetch_ack = 1'b1; exec_done = 1'b0; intr_pend = 1'b0;
        ir_opcode = 7'b0010011; ir_func3 = 3'b000;
        br_eq = 1'b0; br_lt = 1'b0; br_ltu = 1'b0;
        branch_tgt = 32'h0000_0040; jal_tgt = 32'h0; jalr_tgt = 32'h0;
        mtvec = 32'h0000_0100; mepc = 32'h0;

        // Reset with fetch_ack held high: one BOOT cycle, then FETCH, then EXEC.
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RST = 1'b0;
        check("boot.fetch_req", 32'(fetch_req), 32'd0);
        check("boot.pc", pc, 32'h0);
        check("boot.taken_cnt", 32'(taken_cnt), 32'd0);
        check("boot.trap", 32'(trap | misalign), 32'd0);
        @(posedge CLK); #1;
        check("fetch1.fetch_req", 32'(fetch_req), 32'd1);
        check("fetch1.pc", pc, 32'h0);
        @(posedge CLK); #1;
        fetch_ack = 1'b0;
        check("exec1.fetch_req", 32'(fetch_req), 32'd0);
        check("exec1.pc", pc, 32'h0);

        exec_instr("beq", OP_BRANCH, F3_BEQ, 1, 0, 0, 0, 1, 0, 0, 0, 32'h0000_0040);
        do_fetch("f2");
        exec_instr("bgeu", OP_BRANCH, F3_BGEU, 0, 0, 1, 0, 0, 0, 0, 0, 32'h0000_0044);
        do_fetch("f3");
        jalr_tgt = 32'h0000_0103;
        exec_instr("jalr_mis", OP_JALR, 3'b000, 0, 0, 0, 0, 1, 1, 1, 0, 32'h0000_0100);
        do_fetch("f4");
        jal_tgt = 32'h0000_0300;
        exec_instr("jal_intr", OP_JAL, 3'b000, 0, 0, 0, 1, 1, 1, 0, 0, 32'h0000_0100);
        do_fetch("f5");
        mepc = 32'h0000_0200;
        exec_instr("mret", OP_SYSTEM, F3_MRET, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0200);
        do_fetch("f6");
        jal_tgt = 32'hFFFF_FFFC;
        exec_instr("jal_top", OP_JAL, 3'b000, 0, 0, 0, 0, 1, 0, 0, 0, 32'hFFFF_FFFC);
        do_fetch("f7");
        exec_instr("wrap", 7'b0110011, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0000);
        do_fetch("f8");
        exec_instr("illegal", OP_BRANCH, 3'b010, 1, 1, 1, 0, 0, 0, 0, 1, 32'h0000_0004);
        do_fetch("f9");
        branch_tgt = 32'h0000_0042;
        exec_instr("blt_mis", OP_BRANCH, F3_BLT, 0, 1, 0, 0, 1, 1, 1, 0, 32'h0000_0100);

        branch_tgt = 32'h0000_0040;
        for (int i = 0; i < 20; i++) begin
            do_fetch("fl");
            exec_instr("bne_sat", OP_BRANCH, F3_BNE, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0000_0040);
        end
        check("sat.taken_cnt", 32'(taken_cnt), 32'h0000_000F);

        // Reset arriving mid-FETCH overrides a simultaneous ack.
        check("midrst.pre_fetch_req", 32'(fetch_req), 32'd1);
        RST = 1'b1;
        fetch_ack = 1'b1;
        @(posedge CLK); #1;
        check("midrst.fetch_req", 32'(fetch_req), 32'd0);
        check("midrst.pc", pc, 32'h0);
        check("midrst.taken_cnt", 32'(taken_cnt), 32'd0);
        RST = 1'b0;
        fetch_ack = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
